// File: rtl/alu_ctrl_seq_pkg.sv
// alu_ctrl_pkg: shared opcode values, beat indices and opcode-class helpers
// for the ALU control sequencer.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_MUL = 4'h4;
    localparam logic [3:0] OP_DIV = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_AND = 4'h8;
    localparam logic [3:0] OP_XOR = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hC;

    localparam int B_FETCH  = 0;
    localparam int B_DECODE = 1;
    localparam int B_LDA    = 2;
    localparam int B_LDB    = 3;
    localparam int B_DVS    = 4;
    localparam int B_EXEC   = 5;
    localparam int B_WB1    = 6;
    localparam int B_WB2    = 7;

    // MUL and DIV produce two result bytes and need the T7 beat
    function automatic logic is_long(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_alu(input logic [3:0] op);
        return (op >= OP_MOV) && (op <= OP_SHR);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_HLT;
    endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Control bus between the instruction sequencer (master) and the ALU / IR
// side (slave). STEP exists only when ALU_CTRL_STEP_EN is defined.
interface alu_ctrl_seq_if;
    logic       RUN;
    logic [7:0] IR;
`ifdef ALU_CTRL_STEP_EN
    logic       STEP;
`endif
    logic [7:0] T;
    logic       IMOV, IADD, ISUB, IMUL, IDIV, IOR, INOT, IAND, IXOR, ISHL, ISHR;
    logic       EALU;
    logic       IR_LD;
    logic       LDA;
    logic       LDB;
    logic       DVS_LD;
    logic       WR_LO;
    logic       WR_HI;
    logic       BUSY;
    logic       HALTED;
    logic       ILL;

    modport master (
        input  RUN, IR,
`ifdef ALU_CTRL_STEP_EN
        input  STEP,
`endif
        output T, IMOV, IADD, ISUB, IMUL, IDIV, IOR, INOT, IAND, IXOR, ISHL, ISHR,
        output EALU, IR_LD, LDA, LDB, DVS_LD, WR_LO, WR_HI, BUSY, HALTED, ILL
    );

    modport slave (
        output RUN, IR,
`ifdef ALU_CTRL_STEP_EN
        output STEP,
`endif
        input  T, IMOV, IADD, ISUB, IMUL, IDIV, IOR, INOT, IAND, IXOR, ISHL, ISHR,
        input  EALU, IR_LD, LDA, LDB, DVS_LD, WR_LO, WR_HI, BUSY, HALTED, ILL
    );
endinterface

// File: rtl/alu_ctrl_seq_t_ring.sv
// t_ring: 8-beat one-hot timing ring. T0 leaves only on i_adv; T6 wraps home
// when i_wrap6 is set, T7 always wraps, i_home forces an early return, and
// i_hold freezes the ring.
module t_ring
    import alu_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_adv,
    input  logic       i_hold,
    input  logic       i_wrap6,
    input  logic       i_home,
    output logic [7:0] o_t
);

    logic [7:0] r_t;

    // Rotate the one-hot beat; every path lands on a single set bit
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_t <= 8'h01;
        end else if (!i_hold) begin
            if (r_t[B_FETCH]) begin
                if (i_adv) r_t <= 8'h02;
            end else if (i_home || (i_wrap6 && r_t[B_WB1]) || r_t[B_WB2]) begin
                r_t <= 8'h01;
            end else begin
                r_t <= {r_t[6:0], 1'b0};
            end
        end
    end

    assign o_t = r_t;

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: instruction-timing sequencer for the ALU. Captures the opcode
// at T0, runs the beat ring and decodes function / load / write-back strobes.
// Optional single-step gating is enabled by defining ALU_CTRL_STEP_EN.
module alu_ctrl_seq #(
    parameter int OPW       = 4,
    parameter int RUN_WIDTH = 8
) (
    input logic         CLK,
    input logic         RST,
    alu_ctrl_seq_if.master bus
);
    import alu_ctrl_pkg::*;

    if (RUN_WIDTH != 8) begin : g_bad_run_width
        $error("alu_ctrl_seq: RUN_WIDTH must be 8");
    end

    logic           w_step;
    logic [OPW-1:0] w_ir_op;
    logic           w_unused_ir;
    logic           w_fetch;
    logic [7:0]     w_t;
    logic           w_alu;
    logic           w_long;
    logic [OPW-1:0] r_op;
    logic           r_halted;
    logic           r_ill;

`ifdef ALU_CTRL_STEP_EN
    assign w_step = bus.STEP;
`else
    assign w_step = 1'b1;
`endif

    assign w_ir_op     = bus.IR[7 -: OPW];
    assign w_unused_ir = ^bus.IR[7-OPW:0];
    assign w_fetch     = w_t[B_FETCH] & bus.RUN & ~r_halted & w_step;

    t_ring u_ring (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_adv   (w_fetch),
        .i_hold  (~w_step),
        .i_wrap6 (~is_long(r_op)),
        .i_home  (r_op == OP_HLT),
        .o_t     (w_t)
    );

    // Opcode capture at fetch; illegal codes run as NOP with a one-beat ILL
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_op     <= OP_NOP;
            r_halted <= 1'b0;
            r_ill    <= 1'b0;
        end else if (w_step) begin
            r_ill <= 1'b0;
            if (w_fetch) begin
                if (is_illegal(w_ir_op)) begin
                    r_op  <= OP_NOP;
                    r_ill <= 1'b1;
                end else begin
                    r_op <= w_ir_op;
                end
                if (w_ir_op == OP_HLT) r_halted <= 1'b1;
            end
        end
    end

    // Strobes decode from registered state only; function selects drop at T0
    always_comb begin
        w_alu  = is_alu(r_op) & ~w_t[B_FETCH];
        w_long = is_long(r_op);
    end

    assign bus.T      = w_t;
    assign bus.IMOV   = w_alu & (r_op == OP_MOV);
    assign bus.IADD   = w_alu & (r_op == OP_ADD);
    assign bus.ISUB   = w_alu & (r_op == OP_SUB);
    assign bus.IMUL   = w_alu & (r_op == OP_MUL);
    assign bus.IDIV   = w_alu & (r_op == OP_DIV);
    assign bus.IOR    = w_alu & (r_op == OP_OR);
    assign bus.INOT   = w_alu & (r_op == OP_NOT);
    assign bus.IAND   = w_alu & (r_op == OP_AND);
    assign bus.IXOR   = w_alu & (r_op == OP_XOR);
    assign bus.ISHL   = w_alu & (r_op == OP_SHL);
    assign bus.ISHR   = w_alu & (r_op == OP_SHR);
    assign bus.IR_LD  = w_fetch;
    assign bus.LDA    = w_t[B_LDA] & w_alu & (r_op != OP_MOV);
    assign bus.LDB    = w_t[B_LDB] & w_alu & (r_op != OP_NOT);
    assign bus.DVS_LD = w_t[B_DVS] & (r_op == OP_DIV);
    assign bus.WR_LO  = w_t[B_WB1] & w_alu;
    assign bus.WR_HI  = w_t[B_WB2] & w_long;
    assign bus.EALU   = (w_t[B_WB1] & w_alu) | (w_t[B_WB2] & w_long);
    assign bus.BUSY   = ~w_t[B_FETCH];
    assign bus.HALTED = r_halted;
    assign bus.ILL    = r_ill;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Testbench for alu_ctrl_seq: beat-level reference model checked every
// negative edge, plus directed instruction runs with hand-computed results.
module tb_alu_ctrl_seq;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    alu_ctrl_seq_if bus();

    alu_ctrl_seq dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: current beat number, opcode in flight, flags
    int       m_beat = 0;
    int       m_op   = 0;
    bit       m_halt = 1'b0;
    bit       m_ill  = 1'b0;

    function automatic bit step_now();
`ifdef ALU_CTRL_STEP_EN
        return bus.STEP;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int last_beat(input int op);
        if (op == 12) return 1;
        if (op == 4 || op == 5) return 7;
        return 6;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_beat = 0; m_op = 0; m_halt = 1'b0; m_ill = 1'b0;
        end else if (step_now()) begin
            m_ill = 1'b0;
            if (m_beat == 0) begin
                if (bus.RUN && !m_halt) begin
                    m_op = int'(bus.IR[7:4]);
                    if (m_op > 12) begin m_op = 0; m_ill = 1'b1; end
                    if (m_op == 12) m_halt = 1'b1;
                    m_beat = 1;
                end
            end else begin
                m_beat = (m_beat == last_beat(m_op)) ? 0 : m_beat + 1;
            end
        end
    end

    // {func[10:0] IMOV..ISHR, EALU, IR_LD, LDA, LDB, DVS_LD, WR_LO, WR_HI, BUSY, HALTED, ILL}
    function automatic logic [20:0] exp_vec();
        logic [10:0] f;
        bit alu, lng, wlo, whi;
        f   = '0;
        alu = (m_op >= 1 && m_op <= 11);
        lng = (m_op == 4 || m_op == 5);
        if (m_beat != 0 && alu) f[11 - m_op] = 1'b1;
        wlo = (m_beat == 6) && alu;
        whi = (m_beat == 7) && lng;
        return {f, wlo | whi,
                (m_beat == 0) && bus.RUN && !m_halt && step_now(),
                (m_beat == 2) && alu && m_op != 1,
                (m_beat == 3) && alu && m_op != 7,
                (m_beat == 4) && m_op == 5,
                wlo, whi, m_beat != 0, m_halt, m_ill};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {bus.IMOV, bus.IADD, bus.ISUB, bus.IMUL, bus.IDIV, bus.IOR, bus.INOT,
                bus.IAND, bus.IXOR, bus.ISHL, bus.ISHR, bus.EALU, bus.IR_LD, bus.LDA,
                bus.LDB, bus.DVS_LD, bus.WR_LO, bus.WR_HI, bus.BUSY, bus.HALTED, bus.ILL};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        check("model_T", {24'h0, bus.T}, 32'h1 << m_beat);
        check("model_strobes", {11'h0, dut_vec()}, {11'h0, exp_vec()});
    end

    task automatic run_instr(input logic [7:0] ir, output int n, output int ealu_n,
                             output int wrhi_n, output int ill_n);
        n = 0; ealu_n = 0; wrhi_n = 0; ill_n = 0;
        @(negedge CLK); #1 bus.RUN = 1'b1; bus.IR = ir;
        @(negedge CLK); #1 bus.RUN = 1'b0;
        while (bus.T !== 8'h01 && n < 20) begin
            n++;
            if (bus.EALU)  ealu_n++;
            if (bus.WR_HI) wrhi_n++;
            if (bus.ILL)   ill_n++;
            @(negedge CLK); #1;
        end
    endtask

    typedef struct {
        logic [7:0] ir;
        int         len;
        int         ealu;
        int         wrhi;
        int         ill;
    } vec_t;

    vec_t vecs[15] = '{
        '{8'h20, 6, 1, 0, 0}, '{8'h1F, 6, 1, 0, 0}, '{8'h35, 6, 1, 0, 0},
        '{8'h40, 7, 2, 1, 0}, '{8'h50, 7, 2, 1, 0}, '{8'h6A, 6, 1, 0, 0},
        '{8'h70, 6, 1, 0, 0}, '{8'h81, 6, 1, 0, 0}, '{8'h92, 6, 1, 0, 0},
        '{8'hA3, 6, 1, 0, 0}, '{8'hB4, 6, 1, 0, 0}, '{8'h0F, 6, 0, 0, 0},
        '{8'hD0, 6, 0, 0, 1}, '{8'hE0, 6, 0, 0, 1}, '{8'hF7, 6, 0, 0, 1}
    };

    initial begin
        int n, ea, wh, il, wr;
        bus.RUN = 1'b0;
        bus.IR  = 8'h00;
`ifdef ALU_CTRL_STEP_EN
        bus.STEP = 1'b1;
`endif
        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK); #1 bus.RUN = 1'($urandom); bus.IR = 8'($urandom);
        end
        check("rst_T", {24'h0, bus.T}, 32'h01);
        check("rst_busy", {31'h0, bus.BUSY}, 32'h0);
        @(negedge CLK); #1 RST = 1'b0; bus.RUN = 1'b0;
        repeat (10) @(negedge CLK);
        #1 check("idle_T", {24'h0, bus.T}, 32'h01);

        // ADD pinned by hand: T1 then IADD, LDA at T2
        @(negedge CLK); #1 bus.RUN = 1'b1; bus.IR = 8'h20;
        @(negedge CLK); #1 bus.RUN = 1'b0;
        check("add_T1", {24'h0, bus.T}, 32'h02);
        check("add_iadd_T1", {31'h0, bus.IADD}, 32'h1);
        @(negedge CLK); #1 check("add_lda_T2", {31'h0, bus.LDA}, 32'h1);
        repeat (6) @(negedge CLK);
        #1 check("add_back_T0", {24'h0, bus.T}, 32'h01);

        // Opcode sweep
        foreach (vecs[k]) begin
            run_instr(vecs[k].ir, n, ea, wh, il);
            check($sformatf("len_%h", vecs[k].ir), n, vecs[k].len);
            check($sformatf("ealu_%h", vecs[k].ir), ea, vecs[k].ealu);
            check($sformatf("wrhi_%h", vecs[k].ir), wh, vecs[k].wrhi);
            check($sformatf("ill_%h", vecs[k].ir), il, vecs[k].ill);
        end

        // HLT: one beat, then sticky idle despite RUN
        run_instr(8'hC0, n, ea, wh, il);
        check("hlt_len", n, 1);
        bus.RUN = 1'b1;
        repeat (10) @(negedge CLK);
        #1 check("hlt_T", {24'h0, bus.T}, 32'h01);
        check("hlt_flag", {31'h0, bus.HALTED}, 32'h1);
        bus.RUN = 1'b0;
        RST = 1'b1;
        @(negedge CLK); #1 RST = 1'b0;
        check("hlt_cleared", {31'h0, bus.HALTED}, 32'h0);

        // Abort a MUL at T4
        @(negedge CLK); #1 bus.RUN = 1'b1; bus.IR = 8'h40;
        @(negedge CLK); #1 bus.RUN = 1'b0;
        n = 0;
        while (bus.T !== 8'h10 && n < 20) begin
            n++; @(negedge CLK); #1;
        end
        check("abort_reach_T4", n, 3);
        #2 RST = 1'b1;
        #1 check("abort_T", {24'h0, bus.T}, 32'h01);
        check("abort_imul", {31'h0, bus.IMUL}, 32'h0);
        check("abort_wr", {30'h0, bus.WR_LO, bus.WR_HI}, 32'h0);
        @(negedge CLK); #1 RST = 1'b0;
        wr = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK); #1;
            if (bus.WR_LO || bus.WR_HI) wr++;
        end
        check("abort_no_wb", wr, 0);

`ifdef ALU_CTRL_STEP_EN
        // Single-step: 10 STEP pulses on a repeating SUB
        @(negedge CLK); #1 bus.STEP = 1'b0; bus.RUN = 1'b1; bus.IR = 8'h30;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK); #1 bus.STEP = (i % 3 == 2);
        end
        @(negedge CLK); #1 bus.STEP = 1'b0;
        check("step_T", {24'h0, bus.T}, 32'h08);
        check("step_isub", {31'h0, bus.ISUB}, 32'h1);
        bus.RUN = 1'b0;
        RST = 1'b1;
        @(negedge CLK); #1 RST = 1'b0; bus.STEP = 1'b1;
`endif

        repeat (2) @(negedge CLK);
        #1 $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Instruction-timing sequencer that drives the ALU's control interface.
- Generates the one-hot beat ring T[7:0], decodes the opcode into one-hot ALU function strobes (IMOV..ISHR), and issues EALU, operand-load and write-back strobes.
- Sits between the instruction register / memory bus and the ALU; the ALU consumes its outputs unchanged.

Parameters:
- OPW, 4, opcode field width (IR[7:4]).
- RUN_WIDTH, 8, ring length in beats; fixed at 8, any other value is a configuration error.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- RUN  in  1  permits leaving T0 to start a new instruction.
- IR  in  8  instruction byte on the bus; sampled at T0 when IR_LD=1.
- T  out  8  one-hot beat ring, T[0]..T[7].
- IMOV, IADD, ISUB, IMUL, IDIV, IOR, INOT, IAND, IXOR, ISHL, ISHR  out  1 each  one-hot ALU function select.
- EALU  out  1  ALU tri-state output enable.
- IR_LD  out  1  instruction register load.
- LDA  out  1  load ALU A operand.
- LDB  out  1  load ALU B operand.
- DVS_LD  out  1  load divisor into B (DIV only).
- WR_LO  out  1  write-back of low byte / quotient.
- WR_HI  out  1  write-back of high byte / remainder.
- BUSY  out  1  high while T != T0.
- HALTED  out  1  sticky halt flag.
- ILL  out  1  one-cycle illegal-opcode pulse.

Behaviour:
- Reset (async, immediate):
  - T = 8'b0000_0001.
  - All function strobes, EALU, IR_LD, LDA, LDB, DVS_LD, WR_LO, WR_HI, BUSY, HALTED and ILL = 0.
  - Opcode register = NOP.
  - Reset mid-instruction aborts it with no write-back.
- Opcodes (IR[7:4]): 0 NOP, 1 MOV, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 OR, 7 NOT, 8 AND, 9 XOR, A SHL, B SHR, C HLT; D–F are illegal.
- Beat states:
  - T0 FETCH: IR_LD = RUN & ~HALTED. The ring advances only if IR_LD=1, otherwise it holds T0. The opcode is captured on the same edge.
  - T1 DECODE: function strobes become valid and stay stable through the last beat. ILL pulses here for D–F, which then execute as NOP.
  - T2: LDA for all ALU ops except MOV.
  - T3: LDB for all ALU ops except NOT. The DIV dividend is captured by the ALU here.
  - T4: DVS_LD for DIV only.
  - T5: execute; no strobes.
  - T6: EALU=1 and WR_LO=1 for any ALU op.
  - T7: EALU=1 and WR_HI=1 for MUL/DIV only.
- Length:
  - MUL/DIV take 8 beats (T7 -> T0).
  - Other ALU ops, NOP and illegal opcodes wrap T6 -> T0 (7 beats); T7 is never visited.
- NOP/illegal: the ring runs, but no LDA/LDB/EALU/WR strobes are issued.
- HLT: at T1, HALTED is set and the ring returns to T0 on the next edge. HALTED holds until RST; the sequencer then idles in T0 regardless of RUN.
- Function strobes clear on return to T0. At most one strobe is ever high. EALU is never high outside T6/T7.
- Exactly one bit of T is high in every cycle. BUSY = ~T[0].
- RUN deasserted mid-instruction has no effect; the instruction completes.

Optional Feature:
- Macro: ALU_CTRL_STEP_EN.
- When defined:
  - Adds input STEP (1 bit).
  - The ring advances only on cycles where STEP=1 (a level, sampled each edge); otherwise all outputs hold their current values.
  - The T0 start condition becomes RUN & STEP.
- When undefined: STEP does not exist and the ring advances every cycle as described above.

Decomposition:
- Package alu_ctrl_pkg holds:
  - opcode localparams OP_NOP..OP_HLT;
  - beat index constants B_FETCH..B_WB2;
  - an is_long(op) function (MUL/DIV).
- Sub-module t_ring: 8-bit one-hot ring with advance, early-wrap-at-T6 and hold inputs, plus async reset to T0.
- Decode and strobe logic stay in the top module.

Test Plan:
1. Reset: RST=1 with random inputs -> T=8'h01 and all strobes 0. Release RST with RUN=0 -> T holds 8'h01 for 10 cycles.
2. ADD: RUN=1, IR=8'h20 -> T steps 01,02,04,08,10,20,40 then 01. IADD high from T1 to T6. LDA at T2, LDB at T3, EALU+WR_LO at T6 only. WR_HI never asserts.
3. DIV: IR=8'h50 -> 8 beats. DVS_LD asserts at T4. EALU+WR_LO at T6, EALU+WR_HI at T7, then T=01.
4. Illegal/HLT: IR=8'hE0 -> ILL one pulse at T1 and no EALU. Next IR=8'hC0 -> HALTED=1, T stays 01 with RUN=1 until RST.
5. Abort: MUL issued, RST asserted at T4 -> immediate T=01, IMUL=0, no WR_LO/WR_HI.
6. Step (ALU_CTRL_STEP_EN): IR=8'h30 with STEP pulsed every 3rd cycle -> T advances once per STEP, and outputs are frozen between STEP pulses.
